// File: rtl/axi_to_mem_if.sv
// rtl/axi_to_mem_if.sv - AXI channel bundle with master and slave views
// Purpose: groups the five AXI channels (AW, W, B, AR, R) into one port.
// Ports (members): clk/rstn (carried along, not used by axi_to_mem),
//   aw_*/ar_* address channels, w_* write data, b_* write response,
//   r_* read data. The master drives requests; the slave drives responses.
interface axi_channel #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic                    clk;
  logic                    rstn;

  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output clk, rstn,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  clk, rstn,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_to_mem.sv
// rtl/axi_to_mem.sv - AXI slave that turns bursts into single-beat SRAM accesses
// Purpose: terminates an AXI slave port and serves one transaction at a time
//   on a synchronous single-port SRAM (1-cycle read latency).
// Ports: clk, rst (sync, active-high); axi (axi_channel.slave);
//   mem_req/mem_we/mem_addr/mem_wmask/mem_wdata to the SRAM; mem_rdata from it.
module axi_to_mem #(
  parameter int ID_WIDTH       = 8,
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_channel.slave                 axi,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_wmask,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  localparam int SB  = $clog2(DATA_WIDTH / 8);
  localparam int TOP = SB + MEM_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_BRESP, S_RD_ISSUE, S_RD_DATA} state_t;

  state_t                  r_state, w_state_next;
  logic                    r_prio;       // 0: write wins contention, 1: read wins
  logic [ID_WIDTH-1:0]     r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [7:0]              r_beat;
  logic                    r_oor_seen;
  logic                    r_len_err;
  logic                    r_rd_oor;
  logic                    r_rd_first;   // first RD_DATA cycle: SRAM output is live
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_grant_wr, w_grant_rd;
  logic                    w_oor, w_rlast;
  logic [ADDR_WIDTH-1:0]   w_incr, w_sum, w_mask, w_addr_next;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  assign w_oor   = |r_addr[ADDR_WIDTH-1:TOP];
  assign w_rlast = (r_beat == r_len);

  // Burst address advance; arithmetic wraps at ADDR_WIDTH bits.
  assign w_incr = ADDR_WIDTH'(1) << r_size;
  assign w_sum  = r_addr + w_incr;
  assign w_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
  always_comb begin
    w_addr_next = w_sum;
    case (r_burst)
      2'b00:   w_addr_next = r_addr;
      2'b10:   w_addr_next = (r_addr & ~w_mask) | (w_sum & w_mask);
      default: w_addr_next = w_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_wr   = 1'b0;
    w_grant_rd   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (axi.aw_valid && (!axi.ar_valid || !r_prio)) w_grant_wr = 1'b1;
        else if (axi.ar_valid)                          w_grant_rd = 1'b1;
        if (w_grant_wr)      w_state_next = S_WRITE;
        else if (w_grant_rd) w_state_next = S_RD_ISSUE;
      end
      S_WRITE: begin
        if (axi.w_valid) begin
          mem_req = ~w_oor;
          mem_we  = ~w_oor;
          if (axi.w_last) w_state_next = S_BRESP;
        end
      end
      S_BRESP: begin
        if (axi.b_ready) w_state_next = S_IDLE;
      end
      S_RD_ISSUE: begin
        mem_req      = ~w_oor;
        w_state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (axi.r_ready) w_state_next = w_rlast ? S_IDLE : S_RD_ISSUE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio     <= 1'b0;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beat     <= '0;
      r_oor_seen <= 1'b0;
      r_len_err  <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_rd_first <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_wr || w_grant_rd) begin
            r_id       <= w_grant_wr ? axi.aw_id    : axi.ar_id;
            r_addr     <= w_grant_wr ? axi.aw_addr  : axi.ar_addr;
            r_len      <= w_grant_wr ? axi.aw_len   : axi.ar_len;
            r_size     <= w_grant_wr ? axi.aw_size  : axi.ar_size;
            r_burst    <= w_grant_wr ? axi.aw_burst : axi.ar_burst;
            r_beat     <= '0;
            r_oor_seen <= 1'b0;
            r_len_err  <= 1'b0;
            if (axi.aw_valid && axi.ar_valid) r_prio <= ~r_prio;
          end
        end
        S_WRITE: begin
          if (axi.w_valid) begin
            r_oor_seen <= r_oor_seen | w_oor;
            if (axi.w_last) r_len_err <= (r_beat != r_len);
            r_addr <= w_addr_next;
            r_beat <= r_beat + 8'd1;
          end
        end
        S_RD_ISSUE: begin
          r_rd_oor   <= w_oor;
          r_rd_first <= 1'b1;
        end
        S_RD_DATA: begin
          r_rd_first <= 1'b0;
          if (r_rd_first) r_rdata <= w_rd_word;
          if (axi.r_ready && !w_rlast) begin
            r_addr <= w_addr_next;
            r_beat <= r_beat + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // mem_rdata is only valid in the cycle after the strobe, so the first
  // RD_DATA cycle forwards it and later stall cycles replay the capture.
  assign w_rd_word = r_rd_oor ? '0 : mem_rdata;

  assign mem_addr  = r_addr[TOP-1:SB];
  assign mem_wmask = axi.w_strb;
  assign mem_wdata = axi.w_data;

  assign axi.aw_ready = w_grant_wr;
  assign axi.ar_ready = w_grant_rd;
  assign axi.w_ready  = (r_state == S_WRITE);
  assign axi.b_valid  = (r_state == S_BRESP);
  assign axi.b_id     = r_id;
  assign axi.b_resp   = r_oor_seen ? RESP_DECERR :
                        (r_len_err || r_burst == 2'b11) ? RESP_SLVERR : RESP_OKAY;
  assign axi.b_user   = '0;
  assign axi.r_valid  = (r_state == S_RD_DATA);
  assign axi.r_id     = r_id;
  assign axi.r_data   = r_rd_first ? w_rd_word : r_rdata;
  assign axi.r_resp   = r_rd_oor ? RESP_DECERR :
                        (r_burst == 2'b11) ? RESP_SLVERR : RESP_OKAY;
  assign axi.r_last   = (r_state == S_RD_DATA) && w_rlast;
  assign axi.r_user   = '0;

  logic w_unused;
  assign w_unused = &{1'b0, axi.clk, axi.rstn, axi.aw_lock, axi.aw_cache, axi.aw_prot,
                      axi.aw_qos, axi.aw_region, axi.aw_user, axi.ar_lock, axi.ar_cache,
                      axi.ar_prot, axi.ar_qos, axi.ar_region, axi.ar_user, axi.w_user};
endmodule

// File: tb/tb_axi_to_mem.sv
// tb/tb_axi_to_mem.sv - directed bench for axi_to_mem with an SRAM model
module tb_axi_to_mem;
  localparam int IDW = 8, AW = 48, DW = 64, MAW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();
  assign axi.clk  = clk;
  assign axi.rstn = ~rst;

  logic           mem_req, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [7:0]     mem_wmask;
  logic [63:0]    mem_wdata;
  logic [63:0]    mem_rdata = '0;

  axi_to_mem #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .rst(rst), .axi(axi),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [63:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_wmask[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  logic [12:0] slog[$];
  int          strobe_in_rdata = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      slog.push_back({mem_we, mem_addr});
      if (axi.r_valid) strobe_in_rdata++;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] outvec();
    return {axi.aw_ready, axi.ar_ready, axi.w_ready, axi.b_valid, axi.r_valid, mem_req,
            mem_we, axi.b_resp, axi.r_resp, axi.r_last, axi.b_id, axi.r_id, axi.r_data};
  endfunction

  task automatic send_aw(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int tries);
    bit done = 0;
    axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len;
    axi.aw_size = size; axi.aw_burst = burst; axi.aw_valid = 1'b1;
    tries = 0;
    for (int t = 1; t <= 50 && !done; t++) begin
      #1; done = axi.aw_ready; tries = t;
      tick();
    end
    if (!done) check("aw_timeout", 0, 1);
    axi.aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len;
    axi.ar_size = size; axi.ar_burst = burst; axi.ar_valid = 1'b1;
    for (int t = 1; t <= 50 && !done; t++) begin
      #1; done = axi.ar_ready;
      tick();
    end
    if (!done) check("ar_timeout", 0, 1);
    axi.ar_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input bit last);
    bit done = 0;
    axi.w_data = data; axi.w_strb = strb; axi.w_last = last; axi.w_valid = 1'b1;
    for (int t = 1; t <= 50 && !done; t++) begin
      #1; done = axi.w_ready;
      tick();
    end
    if (!done) check("w_timeout", 0, 1);
    axi.w_valid = 1'b0;
    axi.w_last  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [7:0] strb, input logic [63:0] data,
                          output logic [1:0] resp, output logic [7:0] bid, output int tries);
    slog.delete();
    send_aw(id, addr, len, size, burst, tries);
    for (int i = 0; i < nbeats; i++) send_w(data + 64'(i), strb, i == nbeats - 1);
    check("b_valid_after_wlast", axi.b_valid, 1);
    resp = axi.b_resp;
    bid  = axi.b_id;
    axi.b_ready = 1'b1;
    tick();
    axi.b_ready = 1'b0;
  endtask

  logic [63:0] rd_data[$];
  logic [1:0]  rd_resp[$];
  logic        rd_last[$];
  logic [7:0]  rd_id[$];
  int          rd_lat, stall_viol;

  task automatic do_read(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit bp);
    int budget = 300;
    logic [74:0] snap;
    bit fin = 0;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
    slog.delete();
    stall_viol = 0;
    send_ar(id, addr, len, size, burst);
    rd_lat = 1;
    while (budget > 0 && !fin) begin
      if (!axi.r_valid) begin
        tick();
        budget--;
        if (rd_data.size() == 0) rd_lat++;
      end else begin
        if (bp) begin
          int k;
          k = $urandom_range(0, 3);
          snap = {axi.r_data, axi.r_id, axi.r_resp, axi.r_last};
          for (int j = 0; j < k; j++) begin
            tick();
            budget--;
            if (!axi.r_valid || {axi.r_data, axi.r_id, axi.r_resp, axi.r_last} !== snap)
              stall_viol++;
          end
        end
        rd_data.push_back(axi.r_data);
        rd_resp.push_back(axi.r_resp);
        rd_last.push_back(axi.r_last);
        rd_id.push_back(axi.r_id);
        axi.r_ready = 1'b1;
        tick();
        axi.r_ready = 1'b0;
        budget--;
        fin = rd_last[rd_last.size()-1] || rd_data.size() >= 260;
      end
    end
    if (!fin) check("r_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0]  id;
    logic [47:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic        oor;
    logic [11:0] word;
    logic [1:0]  bresp;
    logic [63:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t        vecs[7];
  logic [1:0]  resp;
  logic [7:0]  bid;
  int          tries, bcount, both_ready;
  bit          grants[$];

  initial begin
    vecs[0] = '{8'h05, 48'h10, 3'd3, 2'b01, 8'hFF, 64'hDEADBEEF_01234567,
                1'b0, 12'h002, 2'b00, 64'hDEADBEEF_01234567, 2'b00};
    vecs[1] = '{8'h01, 48'h10, 3'd0, 2'b01, 8'h0F, 64'h11111111_AAAAAAAA,
                1'b0, 12'h002, 2'b00, 64'hDEADBEEF_AAAAAAAA, 2'b00};
    vecs[2] = '{8'h02, 48'h7FF8, 3'd3, 2'b01, 8'hFF, 64'h01234567_89ABCDEF,
                1'b0, 12'hFFF, 2'b00, 64'h01234567_89ABCDEF, 2'b00};
    vecs[3] = '{8'h03, 48'h8000, 3'd3, 2'b01, 8'hFF, 64'h55555555_55555555,
                1'b1, 12'h000, 2'b11, 64'h0, 2'b11};
    vecs[4] = '{8'h04, 48'h20, 3'd3, 2'b11, 8'hF0, 64'hCAFEF00D_12345678,
                1'b0, 12'h004, 2'b10, 64'hCAFEF00D_00000000, 2'b10};
    vecs[5] = '{8'hA5, 48'h1_0000_0038, 3'd3, 2'b01, 8'hFF, 64'h77,
                1'b1, 12'h000, 2'b11, 64'h0, 2'b11};
    vecs[6] = '{8'h06, 48'h3F, 3'd3, 2'b00, 8'h80, 64'hAB000000_00000055,
                1'b0, 12'h007, 2'b00, 64'hAB000000_00000000, 2'b00};

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    {axi.aw_id, axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock} = '0;
    {axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region, axi.aw_user, axi.aw_valid} = '0;
    {axi.ar_id, axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock} = '0;
    {axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region, axi.ar_user, axi.ar_valid} = '0;
    {axi.w_data, axi.w_strb, axi.w_last, axi.w_user, axi.w_valid} = '0;
    axi.b_ready = 1'b0;
    axi.r_ready = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs_in_reset", outvec(), 0);
    rst = 1'b0;
    tick();
    check("reset_outputs_after", outvec(), 0);

    // Contention from reset: write wins first, then grants alternate.
    axi.aw_id = 8'h11; axi.aw_addr = 48'h300; axi.aw_len = 0; axi.aw_size = 3; axi.aw_burst = 1;
    axi.ar_id = 8'h22; axi.ar_addr = 48'h308; axi.ar_len = 0; axi.ar_size = 3; axi.ar_burst = 1;
    axi.w_data = 64'h1234; axi.w_strb = 8'hFF; axi.w_last = 1'b1; axi.w_valid = 1'b1;
    axi.b_ready = 1'b1; axi.r_ready = 1'b1;
    axi.aw_valid = 1'b1; axi.ar_valid = 1'b1;
    both_ready = 0;
    repeat (24) begin
      #1;
      if (axi.aw_ready && axi.ar_ready) both_ready++;
      if (axi.aw_ready) grants.push_back(1'b1);
      else if (axi.ar_ready) grants.push_back(1'b0);
      tick();
    end
    axi.aw_valid = 1'b0; axi.ar_valid = 1'b0;
    repeat (4) tick();
    axi.w_valid = 1'b0; axi.w_last = 1'b0; axi.b_ready = 1'b0; axi.r_ready = 1'b0;
    check("contend_both_ready", both_ready, 0);
    check("contend_grant_count", grants.size() >= 6, 1);
    if (grants.size() >= 6)
      for (int i = 0; i < 6; i++)
        check($sformatf("contend_grant%0d_is_write", i), grants[i], (i % 2) == 0);
    tick();

    // Single-beat write/read-back table.
    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, 1,
               vecs[i].strb, vecs[i].wdata, resp, bid, tries);
      check($sformatf("v%0d_bresp", i), resp, vecs[i].bresp);
      check($sformatf("v%0d_bid", i), bid, vecs[i].id);
      if (vecs[i].oor) check($sformatf("v%0d_wr_strobes", i), slog.size(), 0);
      else begin
        check($sformatf("v%0d_wr_strobes", i), slog.size(), 1);
        if (slog.size() == 1) check($sformatf("v%0d_wr_addr", i), slog[0], {1'b1, vecs[i].word});
      end
      do_read(vecs[i].id ^ 8'h80, vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, 1'b0);
      check($sformatf("v%0d_rd_beats", i), rd_data.size(), 1);
      if (rd_data.size() == 1) begin
        check($sformatf("v%0d_rdata", i), rd_data[0], vecs[i].rdata);
        check($sformatf("v%0d_rresp", i), rd_resp[0], vecs[i].rresp);
        check($sformatf("v%0d_rlast", i), rd_last[0], 1);
        check($sformatf("v%0d_rid", i), rd_id[0], vecs[i].id ^ 8'h80);
      end
      if (vecs[i].oor) check($sformatf("v%0d_rd_strobes", i), slog.size(), 0);
      else begin
        check($sformatf("v%0d_rd_strobes", i), slog.size(), 1);
        if (slog.size() == 1) check($sformatf("v%0d_rd_addr", i), slog[0], {1'b0, vecs[i].word});
      end
    end

    // WRAP read: words 3,0,1,2; r_valid two cycles after AR handshake.
    for (int i = 0; i < 4; i++) mem[i] = 64'h100 + 64'(i);
    do_read(8'h33, 48'h18, 8'd3, 3'd3, 2'b10, 1'b0);
    check("wrap_latency", rd_lat, 2);
    check("wrap_beats", rd_data.size(), 4);
    check("wrap_strobes", slog.size(), 4);
    if (rd_data.size() == 4 && slog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("wrap_addr%0d", i), slog[i], {1'b0, 12'((i + 3) % 4)});
        check($sformatf("wrap_data%0d", i), rd_data[i], 64'h100 + 64'((i + 3) % 4));
        check($sformatf("wrap_last%0d", i), rd_last[i], i == 3);
      end

    // INCR len=7 read with random R backpressure.
    for (int i = 0; i < 8; i++) mem[12'h40 + i] = 64'h1000 + 64'(i);
    strobe_in_rdata = 0;
    do_read(8'h44, 48'h200, 8'd7, 3'd3, 2'b01, 1'b1);
    check("bp_beats", rd_data.size(), 8);
    check("bp_stable", stall_viol, 0);
    check("bp_no_strobe_in_rdata", strobe_in_rdata, 0);
    check("bp_strobes", slog.size(), 8);
    if (rd_data.size() == 8 && slog.size() == 8)
      for (int i = 0; i < 8; i++) begin
        check($sformatf("bp_data%0d", i), rd_data[i], 64'h1000 + 64'(i));
        check($sformatf("bp_last%0d", i), rd_last[i], i == 7);
        check($sformatf("bp_addr%0d", i), slog[i], {1'b0, 12'h40 + 12'(i)});
      end

    // Out-of-range burst write: DECERR, no strobes.
    do_write(8'h55, 48'h8000, 8'd1, 3'd3, 2'b01, 2, 8'hFF, 64'h9, resp, bid, tries);
    check("decerr_bresp", resp, 2'b11);
    check("decerr_strobes", slog.size(), 0);

    // Early w_last: SLVERR after two real SRAM writes.
    do_write(8'h66, 48'h400, 8'd3, 3'd3, 2'b01, 2, 8'hFF, 64'hA0, resp, bid, tries);
    check("slverr_bresp", resp, 2'b10);
    check("slverr_strobes", slog.size(), 2);
    if (slog.size() == 2) begin
      check("slverr_addr0", slog[0], {1'b1, 12'h080});
      check("slverr_addr1", slog[1], {1'b1, 12'h081});
    end

    // Reset during beat 2 of a len=7 write.
    send_aw(8'h77, 48'h500, 8'd7, 3'd3, 2'b01, tries);
    send_w(64'h1, 8'hFF, 1'b0);
    send_w(64'h2, 8'hFF, 1'b0);
    axi.w_data = 64'h3; axi.w_strb = 8'hFF; axi.w_valid = 1'b1;
    rst = 1'b1;
    tick();
    axi.w_valid = 1'b0;
    check("midrst_outputs", outvec(), 0);
    rst = 1'b0;
    bcount = 0;
    repeat (5) begin
      #1;
      if (axi.b_valid) bcount++;
      tick();
    end
    check("midrst_no_bvalid", bcount, 0);
    do_write(8'h78, 48'h508, 8'd0, 3'd3, 2'b01, 1, 8'hFF, 64'hBEEF, resp, bid, tries);
    check("midrst_aw_first_try", tries, 1);
    check("midrst_bresp", resp, 2'b00);
    check("midrst_bid", bid, 8'h78);
    check("midrst_strobes", slog.size(), 1);
    if (slog.size() == 1) check("midrst_addr", slog[0], {1'b1, 12'h0A1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
